// File: rtl/dpram_port_arbiter_if.sv
// Requester-side handshake bundle for dpram_port_arbiter: two req/ack channels
// carrying one RAM access each.
interface dpram_port_arbiter_if #(
    parameter int addr_width_g = 10,
    parameter int data_width_g = 8
);
    logic                    req0;
    logic                    req1;
    logic                    we0;
    logic                    we1;
    logic [addr_width_g-1:0] addr0;
    logic [addr_width_g-1:0] addr1;
    logic [data_width_g-1:0] wdata0;
    logic [data_width_g-1:0] wdata1;
    logic                    ack0;
    logic                    ack1;
    logic [data_width_g-1:0] rdata0;
    logic [data_width_g-1:0] rdata1;

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
        input  ack0, ack1, rdata0, rdata1
    );

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
        output ack0, ack1, rdata0, rdata1
    );
endinterface

// File: rtl/dpram_port_arbiter.sv
// Shares one registered-output RAM port between two req/ack requesters,
// one access per grant (IDLE -> ISSUE -> CAPTURE -> ACK).
module dpram_port_arbiter #(
    parameter int addr_width_g = 10,
    parameter int data_width_g = 8,
    parameter int fixed_prio_g = 0
) (
    input  logic                    clock,
    input  logic                    reset_n,
    dpram_port_arbiter_if.slave     bus,
    output logic                    busy,
    output logic [addr_width_g-1:0] ram_address,
    output logic [data_width_g-1:0] ram_data,
    output logic                    ram_wren,
    input  logic [data_width_g-1:0] ram_q
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_CAPTURE,
        ST_ACK
    } state_t;

    state_t                  state_q, state_d;
    logic                    grant_q, grant_d;
    logic                    last_grant_q, last_grant_d;
    logic [addr_width_g-1:0] ram_address_q, ram_address_d;
    logic [data_width_g-1:0] ram_data_q, ram_data_d;
    logic                    ram_wren_q, ram_wren_d;
    logic                    ack0_q, ack0_d;
    logic                    ack1_q, ack1_d;
    logic [data_width_g-1:0] rdata0_q, rdata0_d;
    logic [data_width_g-1:0] rdata1_q, rdata1_d;
    logic                    win;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            grant_q       <= 1'b0;
            last_grant_q  <= 1'b1;
            ram_address_q <= '0;
            ram_data_q    <= '0;
            ram_wren_q    <= 1'b0;
            ack0_q        <= 1'b0;
            ack1_q        <= 1'b0;
            rdata0_q      <= '0;
            rdata1_q      <= '0;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            last_grant_q  <= last_grant_d;
            ram_address_q <= ram_address_d;
            ram_data_q    <= ram_data_d;
            ram_wren_q    <= ram_wren_d;
            ack0_q        <= ack0_d;
            ack1_q        <= ack1_d;
            rdata0_q      <= rdata0_d;
            rdata1_q      <= rdata1_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        last_grant_d  = last_grant_q;
        ram_address_d = ram_address_q;
        ram_data_d    = ram_data_q;
        ram_wren_d    = 1'b0;
        ack0_d        = 1'b0;
        ack1_d        = 1'b0;
        rdata0_d      = rdata0_q;
        rdata1_d      = rdata1_q;
        win           = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.req0 || bus.req1) begin
                    // On a tie, round-robin favours whoever was not granted last.
                    if (bus.req0 && bus.req1)
                        win = (fixed_prio_g != 0) ? 1'b0 : ~last_grant_q;
                    else
                        win = bus.req1;
                    grant_d       = win;
                    last_grant_d  = win;
                    ram_address_d = win ? bus.addr1  : bus.addr0;
                    ram_data_d    = win ? bus.wdata1 : bus.wdata0;
                    ram_wren_d    = win ? bus.we1    : bus.we0;
                    state_d       = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                state_d = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                if (grant_q) begin
                    rdata1_d = ram_q;
                    ack1_d   = 1'b1;
                end else begin
                    rdata0_d = ram_q;
                    ack0_d   = 1'b1;
                end
                state_d = ST_ACK;
            end
            ST_ACK: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign busy        = (state_q != ST_IDLE);
    assign ram_address = ram_address_q;
    assign ram_data    = ram_data_q;
    assign ram_wren    = ram_wren_q;
    assign bus.ack0    = ack0_q;
    assign bus.ack1    = ack1_q;
    assign bus.rdata0  = rdata0_q;
    assign bus.rdata1  = rdata1_q;

endmodule

// File: tb/tb_dpram_port_arbiter.sv
// Directed bench: a round-robin instance and a fixed-priority instance, each
// backed by a registered-output write-through RAM model.
module tb_dpram_port_arbiter;
    localparam int AW = 10;
    localparam int DW = 8;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;

    dpram_port_arbiter_if #(.addr_width_g(AW), .data_width_g(DW)) bus_rr ();
    dpram_port_arbiter_if #(.addr_width_g(AW), .data_width_g(DW)) bus_fp ();

    logic          busy_rr, wren_rr, busy_fp, wren_fp;
    logic [AW-1:0] addr_rr, addr_fp;
    logic [DW-1:0] data_rr, q_rr, data_fp, q_fp;
    logic [DW-1:0] mem_rr [0:1023];
    logic [DW-1:0] mem_fp [0:1023];

    dpram_port_arbiter #(.addr_width_g(AW), .data_width_g(DW), .fixed_prio_g(0)) u_rr (
        .clock(clock), .reset_n(reset_n), .bus(bus_rr), .busy(busy_rr),
        .ram_address(addr_rr), .ram_data(data_rr), .ram_wren(wren_rr), .ram_q(q_rr)
    );

    dpram_port_arbiter #(.addr_width_g(AW), .data_width_g(DW), .fixed_prio_g(1)) u_fp (
        .clock(clock), .reset_n(reset_n), .bus(bus_fp), .busy(busy_fp),
        .ram_address(addr_fp), .ram_data(data_fp), .ram_wren(wren_fp), .ram_q(q_fp)
    );

    always @(posedge clock) begin
        if (wren_rr) begin
            mem_rr[addr_rr] <= data_rr;
            q_rr            <= data_rr;
        end else begin
            q_rr <= mem_rr[addr_rr];
        end
    end

    always @(posedge clock) begin
        if (wren_fp) begin
            mem_fp[addr_fp] <= data_fp;
            q_fp            <= data_fp;
        end else begin
            q_fp <= mem_fp[addr_fp];
        end
    end

    typedef struct {
        logic          r0;
        logic          w0;
        logic [AW-1:0] a0;
        logic [DW-1:0] d0;
        logic          r1;
        logic          w1;
        logic [AW-1:0] a1;
        logic [DW-1:0] d1;
        logic          who;
        logic [DW-1:0] rd;
        logic          wr;
    } vec_t;

    vec_t vecs [9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_tests++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
        end
    endtask

    task automatic check_rr_reset(input string tag);
        check({tag, "_ack0"},   32'(bus_rr.ack0),   32'd0);
        check({tag, "_ack1"},   32'(bus_rr.ack1),   32'd0);
        check({tag, "_rdata0"}, 32'(bus_rr.rdata0), 32'd0);
        check({tag, "_rdata1"}, 32'(bus_rr.rdata1), 32'd0);
        check({tag, "_addr"},   32'(addr_rr),       32'd0);
        check({tag, "_data"},   32'(data_rr),       32'd0);
        check({tag, "_wren"},   32'(wren_rr),       32'd0);
        check({tag, "_busy"},   32'(busy_rr),       32'd0);
    endtask

    task automatic drop_rr();
        bus_rr.req0 = 1'b0;
        bus_rr.req1 = 1'b0;
        bus_rr.we0  = 1'b0;
        bus_rr.we1  = 1'b0;
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int            cyc;
        int            wr_cnt;
        logic          seen;
        logic [AW-1:0] wa;
        logic [DW-1:0] wd;
        cyc = 0; wr_cnt = 0; seen = 1'b0; wa = '0; wd = '0;
        @(negedge clock);
        bus_rr.req0 = v.r0; bus_rr.we0 = v.w0; bus_rr.addr0 = v.a0; bus_rr.wdata0 = v.d0;
        bus_rr.req1 = v.r1; bus_rr.we1 = v.w1; bus_rr.addr1 = v.a1; bus_rr.wdata1 = v.d1;
        while (!seen && cyc < 10) begin
            @(negedge clock);
            cyc++;
            if (wren_rr) begin
                wr_cnt++;
                wa = addr_rr;
                wd = data_rr;
            end
            if (bus_rr.ack0 || bus_rr.ack1) seen = 1'b1;
        end
        check($sformatf("v%0d_latency", idx), 32'(cyc), 32'd3);
        check($sformatf("v%0d_both_ack", idx), 32'(bus_rr.ack0 & bus_rr.ack1), 32'd0);
        check($sformatf("v%0d_winner_ack", idx), 32'(v.who ? bus_rr.ack1 : bus_rr.ack0), 32'd1);
        check($sformatf("v%0d_rdata", idx), 32'(v.who ? bus_rr.rdata1 : bus_rr.rdata0), 32'(v.rd));
        check($sformatf("v%0d_wren_cycles", idx), 32'(wr_cnt), 32'(v.wr));
        if (v.wr) begin
            check($sformatf("v%0d_wr_addr", idx), 32'(wa), 32'(v.who ? v.a1 : v.a0));
            check($sformatf("v%0d_wr_data", idx), 32'(wd), 32'(v.who ? v.d1 : v.d0));
        end
        drop_rr();
        @(negedge clock);
        check($sformatf("v%0d_ack_cleared", idx), 32'({bus_rr.ack0, bus_rr.ack1}), 32'd0);
        check($sformatf("v%0d_idle_busy", idx), 32'(busy_rr), 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) begin
            mem_rr[i] <= '0;
            mem_fp[i] <= '0;
        end
        mem_rr[10'h005] <= 8'hA7;
        mem_rr[10'h010] <= 8'h5A;
        mem_fp[10'h005] <= 8'h96;
        mem_fp[10'h0AB] <= 8'hC3;
        q_rr <= '0;
        q_fp <= '0;

        drop_rr();
        bus_rr.addr0 = '0; bus_rr.addr1 = '0; bus_rr.wdata0 = '0; bus_rr.wdata1 = '0;
        bus_fp.req0 = 1'b0; bus_fp.req1 = 1'b0; bus_fp.we0 = 1'b0; bus_fp.we1 = 1'b0;
        bus_fp.addr0 = '0; bus_fp.addr1 = '0; bus_fp.wdata0 = '0; bus_fp.wdata1 = '0;

        // Round-robin expectations assume last-grant starts at 1.
        vecs[0] = '{1'b1, 1'b0, 10'h005, 8'h00, 1'b0, 1'b0, 10'h000, 8'h00, 1'b0, 8'hA7, 1'b0};
        vecs[1] = '{1'b0, 1'b0, 10'h000, 8'h00, 1'b1, 1'b1, 10'h1FF, 8'h3C, 1'b1, 8'h3C, 1'b1};
        vecs[2] = '{1'b1, 1'b0, 10'h1FF, 8'h00, 1'b0, 1'b0, 10'h000, 8'h00, 1'b0, 8'h3C, 1'b0};
        vecs[3] = '{1'b1, 1'b1, 10'h020, 8'h11, 1'b1, 1'b1, 10'h021, 8'h22, 1'b1, 8'h22, 1'b1};
        vecs[4] = '{1'b1, 1'b0, 10'h021, 8'h00, 1'b1, 1'b0, 10'h005, 8'h00, 1'b0, 8'h22, 1'b0};
        vecs[5] = '{1'b1, 1'b0, 10'h005, 8'h00, 1'b1, 1'b0, 10'h1FF, 8'h00, 1'b1, 8'h3C, 1'b0};
        vecs[6] = '{1'b1, 1'b1, 10'h020, 8'h11, 1'b0, 1'b0, 10'h000, 8'h00, 1'b0, 8'h11, 1'b1};
        vecs[7] = '{1'b1, 1'b0, 10'h1FF, 8'h00, 1'b1, 1'b0, 10'h020, 8'h00, 1'b1, 8'h11, 1'b0};
        vecs[8] = '{1'b1, 1'b0, 10'h020, 8'h00, 1'b1, 1'b0, 10'h021, 8'h00, 1'b0, 8'h11, 1'b0};

        repeat (3) @(negedge clock);
        check_rr_reset("por");
        check("por_fp_ack", 32'({bus_fp.ack0, bus_fp.ack1}), 32'd0);
        check("por_fp_busy", 32'(busy_fp), 32'd0);
        reset_n = 1'b1;

        for (int i = 0; i < 9; i++) run_vec(i, vecs[i]);

        // Requester keeps req high through ACK with a new address.
        @(negedge clock);
        bus_rr.req0 = 1'b1; bus_rr.we0 = 1'b0; bus_rr.addr0 = 10'h005;
        for (int c = 1; c <= 7; c++) begin
            @(negedge clock);
            check($sformatf("ign_ack0_c%0d", c), 32'(bus_rr.ack0), 32'((c == 3) || (c == 7)));
            if (c == 3) begin
                check("ign_rdata_first", 32'(bus_rr.rdata0), 32'h A7);
                bus_rr.addr0 = 10'h010;
            end
            if (c == 7) begin
                check("ign_rdata_second", 32'(bus_rr.rdata0), 32'h5A);
                drop_rr();
            end
        end
        @(negedge clock);
        check("ign_no_double_ack", 32'(bus_rr.ack0), 32'd0);

        // Reset during ISSUE of a write.
        @(negedge clock);
        bus_rr.req1 = 1'b1; bus_rr.we1 = 1'b1; bus_rr.addr1 = 10'h030; bus_rr.wdata1 = 8'h55;
        @(negedge clock);
        check("mid_wren_issue", 32'(wren_rr), 32'd1);
        check("mid_busy_issue", 32'(busy_rr), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        check("mid_wren_async", 32'(wren_rr), 32'd0);
        check("mid_busy_async", 32'(busy_rr), 32'd0);
        drop_rr();
        for (int c = 0; c < 3; c++) begin
            @(negedge clock);
            check($sformatf("mid_no_ack_rst_c%0d", c), 32'({bus_rr.ack0, bus_rr.ack1}), 32'd0);
        end
        reset_n = 1'b1;
        check_rr_reset("post");
        for (int c = 0; c < 4; c++) begin
            @(negedge clock);
            check($sformatf("mid_no_ack_after_c%0d", c), 32'({bus_rr.ack0, bus_rr.ack1}), 32'd0);
        end
        check("mid_write_lost", 32'(mem_rr[10'h030]), 32'd0);

        // Continuous contention from reset on both instances.
        @(negedge clock);
        reset_n = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        bus_rr.req0 = 1'b1; bus_rr.addr0 = 10'h005;
        bus_rr.req1 = 1'b1; bus_rr.addr1 = 10'h1FF;
        bus_fp.req0 = 1'b1; bus_fp.addr0 = 10'h005;
        bus_fp.req1 = 1'b1; bus_fp.addr1 = 10'h0AB;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clock);
            check($sformatf("rr_ack0_c%0d", c), 32'(bus_rr.ack0), 32'(c % 8 == 3));
            check($sformatf("rr_ack1_c%0d", c), 32'(bus_rr.ack1), 32'(c % 8 == 7));
            if (c % 8 == 3) check($sformatf("rr_rdata0_c%0d", c), 32'(bus_rr.rdata0), 32'hA7);
            if (c % 8 == 7) check($sformatf("rr_rdata1_c%0d", c), 32'(bus_rr.rdata1), 32'h3C);
            check($sformatf("fp_ack0_c%0d", c), 32'(bus_fp.ack0), 32'((c % 4 == 3) && (c <= 15)));
            check($sformatf("fp_ack1_c%0d", c), 32'(bus_fp.ack1), 32'(c == 19));
            if (c % 4 == 3 && c <= 15) check($sformatf("fp_rdata0_c%0d", c), 32'(bus_fp.rdata0), 32'h96);
            if (c == 19) check("fp_rdata1", 32'(bus_fp.rdata1), 32'hC3);
            if (c == 15) bus_fp.req0 = 1'b0;
        end
        drop_rr();
        bus_fp.req0 = 1'b0;
        bus_fp.req1 = 1'b0;
        repeat (2) @(negedge clock);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/dpram_port_arbiter.md
# dpram_port_arbiter

Shares one port of the dual-clock dual-port RAM (dpram_dc) between two requesters on the same clock, e.g. the CPU and the ROM-download/DMA path. Each requester uses a simple req/ack handshake; the block sequences a single registered RAM access per grant and returns the read data. Arbitration is round-robin or fixed priority. The RAM port is driven only by this block.

## Interface
- addr_width_g, 10, RAM address width; must match the RAM instance.
- data_width_g, 8, RAM data width.
- fixed_prio_g, 0, 0 = round-robin; 1 = requester 0 always wins ties.

Ports:
- clock  in  1  system clock; also connected to the RAM port clock.
- reset_n  in  1  asynchronous active-low reset.
- req0 / req1  in  1  access request; held high until the matching ack.
- we0 / we1  in  1  1 = write, 0 = read; stable while req is high.
- addr0 / addr1  in  addr_width_g  access address; stable while req is high.
- wdata0 / wdata1  in  data_width_g  write data; stable while req is high.
- ack0 / ack1  out  1  single-cycle completion pulse.
- rdata0 / rdata1  out  data_width_g  result; valid in the ack cycle and held until the next ack to that requester.
- busy  out  1  high whenever state is not IDLE.
- ram_address  out  addr_width_g  to RAM address.
- ram_data  out  data_width_g  to RAM data.
- ram_wren  out  1  to RAM wren.
- ram_q  in  data_width_g  from RAM q. The RAM output is registered, and write-through returns the written data.

## Operation
- FSM states: IDLE, ISSUE, CAPTURE, ACK.
- **IDLE**
  - If no req: stay.
  - Otherwise: select a winner, register its addr/wdata/we onto ram_address/ram_data/ram_wren, latch the grant index, and go to ISSUE.
- **ISSUE**
  - RAM inputs are valid for exactly this cycle; ram_wren is high only here, and only for writes.
  - Next state: CAPTURE. ram_wren is cleared on the exit edge.
- **CAPTURE**
  - ram_q is valid.
  - On exit edge: rdataN <= ram_q for the granted N, ackN <= 1, next state ACK.
- **ACK**
  - ackN is high for this cycle only.
  - Incoming req lines are ignored. The requester drops req in this cycle.
  - Next state: IDLE unconditionally; ack is cleared.
- **Arbitration** (evaluated only in IDLE)
  - Single request: that requester wins.
  - Both requesting with fixed_prio_g=1: requester 0 wins.
  - Both requesting with fixed_prio_g=0: the requester not granted last time wins.
  - The last-grant register updates on every grant and resets to 1, so requester 0 wins the first tie.
- **Writes**
  - The RAM write happens at the ISSUE→CAPTURE edge.
  - rdataN returns the written value (RAM write-through).
- ram_address and ram_data hold their last values outside ISSUE; only ram_wren matters to the RAM there.
- A req dropped before its ack is a protocol violation. The granted access still completes and acks.

## Timing
- Reset values: state IDLE, ack0/ack1 0, rdata0/rdata1 0, ram_address 0, ram_data 0, ram_wren 0, busy 0, last-grant 1.
- Reset acts immediately (asynchronous).
  - Reset asserted during ISSUE: ram_wren falls with reset, so the write is lost unless the clock edge has already passed.
  - An in-flight ack is never generated after reset.
- Latency:
  - Req sampled high at IDLE edge E0; ack is high in the cycle after E2 (3 cycles).
  - Back-to-back service is one access per 4 cycles.
  - With both requesters continuously requesting in round-robin mode, grants alternate and each is served every 8 cycles.
- busy is combinational from state: high in ISSUE, CAPTURE and ACK.

## Test plan
- Read: preload RAM[0x005]=0xA7; req0 read at 0x005 → ram_wren stays 0; ack0 pulses once 3 cycles after sampling; rdata0=0xA7.
- Write then read:
  - req1 writes 0x3C to 0x1FF → ram_wren high for exactly one cycle, with ram_address=0x1FF and ram_data=0x3C; ack1 pulses with rdata1=0x3C.
  - A following req0 read of 0x1FF → rdata0=0x3C.
- Contention, round-robin: both requesters hold req from reset → grant order is 0,1,0,1; acks spaced 4 cycles apart; no cycle has both acks high.
- Fixed priority (fixed_prio_g=1): both held → requester 0 is served on every access; requester 1 is served only after req0 drops.
- Reset mid-access: assert reset_n=0 during ISSUE of a write → ram_wren drops asynchronously, no ack follows; after release, state is IDLE and all outputs equal their reset values.
- Ignore in ACK: hold req0 high through the ACK cycle with new address 0x010 → the block returns to IDLE and then serves 0x010 as a new access; there is no double ack within a single access.
